// File: rtl/sync_fifo_flags_pkg.sv
// Shared definitions for the FIFO family: default geometry, flag-threshold
// defaults and the depth legality helper.
package sync_fifo_flags_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AE_LEVEL  = 2;
    localparam int DEF_AF_MARGIN = 2;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/sync_fifo_flags_mem.sv
// WIDTH x DEPTH register array with one synchronous write port and one
// registered read port; the read register clears on reset, the array does not.
module fifo_mem_dp #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [PTR_W-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, read-valid strobe and overflow/underflow error pulses.
module sync_fifo_flags
    import sync_fifo_flags_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             rvalid_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [CNT_W-1:0] count_o,
    output logic             wr_error_o,
    output logic             rd_error_o
);

    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $error("sync_fifo_flags: DEPTH=%0d must be a power of 2 and >= 4", DEPTH);
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("sync_fifo_flags: AF_LEVEL=%0d out of range 1..DEPTH", AF_LEVEL);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_flags: AE_LEVEL=%0d out of range 0..DEPTH-1", AE_LEVEL);
    end

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             wr_acc;
    logic             rd_acc;

    // Acceptance uses the registered flags, so a full FIFO never writes through
    // and an empty FIFO never reads through, regardless of the opposite request.
    assign wr_acc = wr_en_i && !full_o;
    assign rd_acc = rd_en_i && !empty_o;

    always_comb begin
        count_next = count_o;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_next = count_o + CNT_W'(1);
            2'b01:   count_next = count_o - CNT_W'(1);
            default: count_next = count_o;
        endcase
    end

    fifo_mem_dp #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk   (clk_i),
        .rst   (rst_i),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (wdata_i),
        .re    (rd_acc),
        .raddr (rd_ptr),
        .rdata (rdata_o)
    );

    // Flags are computed from next-count so they line up with count_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            rvalid_o       <= 1'b0;
            wr_error_o     <= 1'b0;
            rd_error_o     <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count_o        <= count_next;
            full_o         <= (count_next == CNT_W'(DEPTH));
            empty_o        <= (count_next == '0);
            almost_full_o  <= (count_next >= CNT_W'(AF_LEVEL));
            almost_empty_o <= (count_next <= CNT_W'(AE_LEVEL));
            rvalid_o       <= rd_acc;
            wr_error_o     <= wr_en_i && full_o;
            rd_error_o     <= rd_en_i && empty_o;
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Randomised and directed bench for sync_fifo_flags against a queue-based model.
module tb_sync_fifo_flags;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wdata = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rdata;
    logic       rvalid, full, empty, afull, aempty, wr_err, rd_err;
    logic [4:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_rdata  = '0;
    bit         m_rvalid = 0;
    bit         m_wr_err = 0;
    bit         m_rd_err = 0;

    sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wdata_i        (wdata),
        .rd_en_i        (rd_en),
        .rdata_o        (rdata),
        .rvalid_o       (rvalid),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .count_o        (count),
        .wr_error_o     (wr_err),
        .rd_error_o     (rd_err)
    );

    always #5 clk = ~clk;

    // One clock with the given requests; the model advances from pre-edge occupancy.
    task automatic step(input bit wr, input logic [7:0] d, input bit rd);
        bit mf, me;
        wr_en = wr; wdata = d; rd_en = rd;
        @(posedge clk);
        mf = (q.size() == DEPTH);
        me = (q.size() == 0);
        m_wr_err = wr && mf;
        m_rd_err = rd && me;
        m_rvalid = rd && !me;
        if (rd && !me) m_rdata = q.pop_front();
        if (wr && !mf) q.push_back(d);
        #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic do_reset(input bit wr, input bit rd);
        rst = 1; wr_en = wr; rd_en = rd; wdata = 8'hEE;
        @(posedge clk);
        q.delete();
        m_rdata = '0; m_rvalid = 0; m_wr_err = 0; m_rd_err = 0;
        #1;
        rst = 0; wr_en = 0; rd_en = 0;
    endtask

    task automatic test_reset();
        do_reset(0, 0);
        do_reset(1, 1);
        checks += 6;
        if (count !== 5'd0)  begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        if (aempty !== 1'b1) begin errors++; $display("FAIL reset_aempty got %b want 1", aempty); end
        if (full !== 1'b0 || afull !== 1'b0) begin errors++; $display("FAIL reset_full got %b/%b want 0/0", full, afull); end
        if (rvalid !== 1'b0 || wr_err !== 1'b0 || rd_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got rv=%b we=%b re=%b want 0", rvalid, wr_err, rd_err);
        end
        if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h want 00", rdata); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 8'(i), 0);
            checks += 4;
            if (count !== 5'(i)) begin errors++; $display("FAIL fill_count i=%0d got %0d want %0d", i, count, i); end
            if (afull !== (i >= AF)) begin errors++; $display("FAIL fill_afull i=%0d got %b want %b", i, afull, (i >= AF)); end
            if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty i=%0d got %b want 0", i, empty); end
            if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full i=%0d got %b want %b", i, full, (i == DEPTH)); end
        end
        for (int i = 1; i <= DEPTH; i++) begin
            step(0, 8'h00, 1);
            checks += 2;
            if (rdata !== 8'(i)) begin errors++; $display("FAIL drain_rdata i=%0d got %h want %h", i, rdata, 8'(i)); end
            if (rvalid !== 1'b1) begin errors++; $display("FAIL drain_rvalid i=%0d got %b want 1", i, rvalid); end
        end
        checks += 1;
        if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_overflow_underflow();
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom_range(0, 8'hA9)), 0);
        step(1, 8'hAA, 0);
        checks += 2;
        if (wr_err !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b want 1", wr_err); end
        if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got %0d want 16", count); end
        step(0, 8'h00, 0);
        checks += 1;
        if (wr_err !== 1'b0) begin errors++; $display("FAIL ovf_pulse_len got %b want 0", wr_err); end
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 1);
            checks += 1;
            if (rdata !== m_rdata || rdata === 8'hAA) begin
                errors++; $display("FAIL ovf_data i=%0d got %h want %h", i, rdata, m_rdata);
            end
        end
        step(0, 8'h00, 1);
        checks += 2;
        if (rd_err !== 1'b1) begin errors++; $display("FAIL udf_pulse got %b want 1", rd_err); end
        if (rvalid !== 1'b0) begin errors++; $display("FAIL udf_rvalid got %b want 0", rvalid); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) step(1, 8'($urandom), 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'($urandom), 1);
            checks += 2;
            if (count !== 5'd5) begin errors++; $display("FAIL simul_count i=%0d got %0d want 5", i, count); end
            if (rdata !== m_rdata) begin errors++; $display("FAIL simul_data i=%0d got %h want %h", i, rdata, m_rdata); end
        end
        while (q.size() > 0) step(0, 8'h00, 1);
    endtask

    task automatic test_full_empty_rw();
        for (int i = 0; i < DEPTH; i++) step(1, 8'($urandom), 0);
        step(1, 8'h77, 1);
        checks += 3;
        if (count !== 5'd15) begin errors++; $display("FAIL fullrw_count got %0d want 15", count); end
        if (wr_err !== 1'b1 || rvalid !== 1'b1) begin errors++; $display("FAIL fullrw_flags got we=%b rv=%b want 1/1", wr_err, rvalid); end
        if (rdata !== m_rdata) begin errors++; $display("FAIL fullrw_data got %h want %h", rdata, m_rdata); end
        while (q.size() > 0) step(0, 8'h00, 1);
        step(1, 8'h3C, 1);
        checks += 2;
        if (count !== 5'd1) begin errors++; $display("FAIL emptyrw_count got %0d want 1", count); end
        if (rd_err !== 1'b1 || rvalid !== 1'b0) begin errors++; $display("FAIL emptyrw_flags got re=%b rv=%b want 1/0", rd_err, rvalid); end
        step(0, 8'h00, 1);
        checks += 1;
        if (rdata !== 8'h3C) begin errors++; $display("FAIL emptyrw_data got %h want 3c", rdata); end
    endtask

    task automatic test_wrap();
        int writes = 0;
        bit wr, rd;
        for (int i = 0; i < 3; i++) step(1, 8'($urandom), 0);
        for (int cyc = 0; cyc < 400 && writes < 40; cyc++) begin
            wr = ($urandom_range(0, 3) != 0);
            rd = ($urandom_range(0, 3) != 0);
            if (q.size() <= 2) wr = 1;
            if (q.size() >= 4) rd = 1;
            if (wr) writes++;
            step(wr, 8'($urandom), rd);
            checks += 2;
            if (aempty !== (q.size() <= AE)) begin errors++; $display("FAIL wrap_aempty sz=%0d got %b want %b", q.size(), aempty, (q.size() <= AE)); end
            if (rdata !== m_rdata) begin errors++; $display("FAIL wrap_data got %h want %h", rdata, m_rdata); end
        end
        checks += 1;
        if (writes < 40) begin errors++; $display("FAIL wrap_budget got %0d writes want 40", writes); end
        while (q.size() > 0) step(0, 8'h00, 1);
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 9; i++) step(1, 8'(8'h90 + i), 0);
        step(0, 8'h00, 1);
        step(1, 8'h99, 0);
        do_reset(1, 1);
        checks += 3;
        if (count !== 5'd0) begin errors++; $display("FAIL mrst_count got %0d want 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b want 1", empty); end
        if (rvalid !== 1'b0) begin errors++; $display("FAIL mrst_rvalid got %b want 0", rvalid); end
        step(1, 8'h5A, 0);
        step(0, 8'h00, 1);
        checks += 2;
        if (rdata !== 8'h5A) begin errors++; $display("FAIL mrst_data got %h want 5a", rdata); end
        if (count !== 5'd0) begin errors++; $display("FAIL mrst_count2 got %0d want 0", count); end
    endtask

    task automatic test_random();
        int sz;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 199) == 0) do_reset($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            else step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50);
            sz = q.size();
            checks += 9;
            if (count !== 5'(sz)) begin errors++; $display("FAIL rnd_count cyc=%0d got %0d want %0d", cyc, count, sz); end
            if (full !== (sz == DEPTH)) begin errors++; $display("FAIL rnd_full cyc=%0d got %b want %b", cyc, full, (sz == DEPTH)); end
            if (empty !== (sz == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got %b want %b", cyc, empty, (sz == 0)); end
            if (afull !== (sz >= AF)) begin errors++; $display("FAIL rnd_afull cyc=%0d got %b want %b", cyc, afull, (sz >= AF)); end
            if (aempty !== (sz <= AE)) begin errors++; $display("FAIL rnd_aempty cyc=%0d got %b want %b", cyc, aempty, (sz <= AE)); end
            if (rvalid !== m_rvalid) begin errors++; $display("FAIL rnd_rvalid cyc=%0d got %b want %b", cyc, rvalid, m_rvalid); end
            if (wr_err !== m_wr_err) begin errors++; $display("FAIL rnd_wr_err cyc=%0d got %b want %b", cyc, wr_err, m_wr_err); end
            if (rd_err !== m_rd_err) begin errors++; $display("FAIL rnd_rd_err cyc=%0d got %b want %b", cyc, rd_err, m_rd_err); end
            if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h want %h", cyc, rdata, m_rdata); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow_underflow();
        test_simultaneous();
        test_full_empty_rw();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
